// File: rtl/lfsr_decrypt_engine.sv
// lfsr_decrypt_engine: recovers the LFSR tap and seed from a space preamble, then
// decrypts the ciphertext block and writes the space-stripped plaintext to memory.
module lfsr_decrypt_engine #(
  parameter int MSG_BASE  = 64,
  parameter int MSG_LEN   = 64,
  parameter int OUT_LEN   = 41,
  parameter int PRE_CHECK = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic       error,
  output logic [2:0] tap_idx,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);
  localparam int PW = $clog2(PRE_CHECK + 2);
  localparam logic [PW-1:0] PC = PW'(PRE_CHECK);
  localparam logic [7:0] MB = 8'(MSG_BASE);
  localparam logic [7:0] ML = 8'(MSG_LEN);
  localparam logic [7:0] OL = 8'(OUT_LEN);
  localparam logic [7:0] TAPS [8] = '{8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3};
  typedef enum logic [2:0] {IDLE, PRE_RD, SEARCH, SCAN, COPY, PAD, DONE} state_t;
  state_t state;
  logic [7:0] pre [0:PRE_CHECK];
  logic [7:0] s, s0, ra, i, wp;
  logic [2:0] k;
  logic [PW-1:0] j, rc;
  logic rv, ph;
  logic [7:0] nxt, p;
  assign nxt = {s[6:0], ^(s & TAPS[k])};
  assign p = mem_rdata ^ s;
  // pre[] holds the preamble already xor'ed with 0x20, i.e. the expected LFSR states
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      done <= 1'b0;
      error <= 1'b0;
      tap_idx <= '0;
      mem_addr <= '0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      mem_wdata <= '0;
      s <= '0;
      s0 <= '0;
      ra <= '0;
      i <= '0;
      wp <= '0;
      k <= '0;
      j <= '0;
      rc <= '0;
      rv <= 1'b0;
      ph <= 1'b0;
      for (int n = 0; n <= PRE_CHECK; n++) pre[n] <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= PRE_RD;
          done <= 1'b0;
          error <= 1'b0;
          mem_rd <= 1'b1;
          mem_addr <= MB;
          rc <= '0;
        end
        PRE_RD: begin
          if (rc != '0) pre[rc - 1'b1] <= mem_rdata ^ 8'h20;
          rc <= rc + 1'b1;
          mem_rd <= rc < PC;
          mem_addr <= MB + 8'(rc) + 8'd1;
          if (rc == PC + 1'b1) begin
            state <= SEARCH;
            s <= pre[0];
            s0 <= pre[0];
            k <= '0;
            j <= PW'(1);
          end
        end
        SEARCH: if (nxt == pre[j]) begin
          s <= nxt;
          j <= j + 1'b1;
          if (j == PC) begin
            state <= SCAN;
            tap_idx <= k;
            s <= s0;
            ra <= 8'd1;
            i <= '0;
            rv <= 1'b0;
            mem_rd <= 1'b1;
            mem_addr <= MB;
          end
        end else if (k == 3'd7) begin
          state <= DONE;
          error <= 1'b1;
          done <= 1'b1;
        end else begin
          k <= k + 1'b1;
          s <= s0;
          j <= PW'(1);
        end
        SCAN: begin
          rv <= mem_rd;
          mem_rd <= ra < ML;
          mem_addr <= MB + ra;
          ra <= ra + 8'd1;
          if (rv) begin
            s <= nxt;
            i <= i + 8'd1;
            if (p != 8'h20) begin
              state <= COPY;
              ph <= 1'b1;
              mem_rd <= 1'b0;
              mem_wr <= 1'b1;
              mem_addr <= '0;
              mem_wdata <= p;
              wp <= '0;
            end else if (i == ML - 8'd1) begin
              state <= PAD;
              mem_rd <= 1'b0;
              mem_wr <= 1'b1;
              mem_addr <= '0;
              mem_wdata <= 8'h20;
              wp <= '0;
            end
          end
        end
        // ph=1: write cycle, rdata carries byte i from the read issued in the ph=0 cycle
        COPY: if (ph) begin
          ph <= 1'b0;
          wp <= wp + 8'd1;
          mem_wr <= 1'b0;
          if (wp == OL - 8'd1) begin
            state <= DONE;
            done <= 1'b1;
          end else if (i == ML) begin
            state <= PAD;
            mem_wr <= 1'b1;
            mem_addr <= wp + 8'd1;
            mem_wdata <= 8'h20;
          end else begin
            mem_wdata <= p;
            s <= nxt;
            i <= i + 8'd1;
            mem_rd <= i + 8'd1 < ML;
            mem_addr <= MB + i + 8'd1;
          end
        end else begin
          ph <= 1'b1;
          mem_rd <= 1'b0;
          mem_wr <= 1'b1;
          mem_addr <= wp;
        end
        PAD: begin
          wp <= wp + 8'd1;
          mem_addr <= wp + 8'd1;
          if (wp == OL - 8'd1) begin
            state <= DONE;
            done <= 1'b1;
            mem_wr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
